// File: rtl/line_streamer.sv
// ----------------------------------------------------------------------------
// line_streamer
// Packs a pixel-serial stream (one image pixel plus NUM_TEMPLATES template
// pixels per handshake) into LINE_SIZE-wide lines for the Top correlator.
// Each completed line is presented on registered outputs together with a
// one-cycle line_valid strobe. A frame is NUM_OF_LINES lines. It opens with a
// one-cycle acc_clear pulse and closes with a one-cycle frame_done pulse.
//
// Ports
//   clk_i          clock, rising edge
//   reset_i        synchronous, active-high reset
//   start_i        begin a frame (only looked at while idle)
//   pix_valid_i    I_pix_i / T_pix_i carry a pixel
//   pix_ready_o    pixel is accepted this cycle when pix_valid_i is high
//   I_pix_i        image pixel
//   T_pix_i        template pixels of the same column, template t at
//                  bits [t*PIXEL_SIZE +: PIXEL_SIZE]
//   I_in_line_o    assembled image line, column j at [j*PIXEL_SIZE +: PIXEL_SIZE]
//   T_in_line_o    assembled template lines, column j / template t at
//                  [(j*NUM_TEMPLATES+t)*PIXEL_SIZE +: PIXEL_SIZE]
//   line_valid_o   one-cycle strobe: line outputs hold a new line
//   line_idx_o     index of the line on the outputs
//   acc_clear_o    one-cycle pulse clearing the Top accumulators
//   frame_done_o   one-cycle pulse in the cycle after the last line strobe
// ----------------------------------------------------------------------------
module line_streamer #(
    parameter int PIXEL_SIZE    = 8,
    parameter int LINE_SIZE     = 64,
    parameter int NUM_TEMPLATES = 1,
    parameter int NUM_OF_LINES  = 64,
    localparam int LIDX_W = (NUM_OF_LINES > 1) ? $clog2(NUM_OF_LINES) : 1,
    localparam int TPIX_W = NUM_TEMPLATES * PIXEL_SIZE,
    localparam int ILINE_W = LINE_SIZE * PIXEL_SIZE,
    localparam int TLINE_W = LINE_SIZE * TPIX_W
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               pix_valid_i,
    output logic               pix_ready_o,
    input  logic [PIXEL_SIZE-1:0] I_pix_i,
    input  logic [TPIX_W-1:0]  T_pix_i,
    output logic [ILINE_W-1:0] I_in_line_o,
    output logic [TLINE_W-1:0] T_in_line_o,
    output logic               line_valid_o,
    output logic [LIDX_W-1:0]  line_idx_o,
    output logic               acc_clear_o,
    output logic               frame_done_o
);

    localparam int COL_W = (LINE_SIZE > 1) ? $clog2(LINE_SIZE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        FILL,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [LIDX_W-1:0]  line_q, line_d;

    logic [ILINE_W-1:0] iBuf_q;
    logic [TLINE_W-1:0] tBuf_q;
    logic [ILINE_W-1:0] iLine_q;
    logic [TLINE_W-1:0] tLine_q;
    logic [LIDX_W-1:0]  lineIdx_q;
    logic               lineValid_q;
    logic               frameDone_q;

    logic               accept;
    logic               lastCol;
    logic               lastLine;
    logic               lineLoad;
    logic [ILINE_W-1:0] iLineNext;
    logic [TLINE_W-1:0] tLineNext;

    assign accept   = pix_valid_i && pix_ready_o;
    assign lastCol  = (col_q == COL_W'(LINE_SIZE - 1));
    assign lastLine = (line_q == LIDX_W'(NUM_OF_LINES - 1));
    assign lineLoad = accept && lastCol;

    // State and counter registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            col_q   <= '0;
            line_q  <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            line_q  <= line_d;
        end
    end

    // Next-state logic. The counters only move on an accepted pixel, so
    // pix_valid gaps in FILL simply hold everything.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        pix_ready_o = 1'b0;
        acc_clear_o = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = CLEAR;
                end
            end
            CLEAR: begin
                acc_clear_o = 1'b1;
                col_d       = '0;
                line_d      = '0;
                state_d     = FILL;
            end
            FILL: begin
                pix_ready_o = 1'b1;
                if (accept) begin
                    if (lastCol) begin
                        col_d = '0;
                        if (lastLine) begin
                            line_d  = '0;
                            state_d = DONE;
                        end else begin
                            line_d = line_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The final column bypasses the fill buffer so the line can be loaded on
    // the same edge that accepts its last pixel.
    always_comb begin
        iLineNext = iBuf_q;
        tLineNext = tBuf_q;
        iLineNext[(LINE_SIZE - 1) * PIXEL_SIZE +: PIXEL_SIZE] = I_pix_i;
        tLineNext[(LINE_SIZE - 1) * TPIX_W +: TPIX_W]         = T_pix_i;
    end

    // Fill buffer and presented-line registers are separate, so pixels of
    // the next line never disturb the line Top is looking at. frame_done is
    // delayed one cycle past DONE so it never overlaps the final line strobe.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            iBuf_q      <= '0;
            tBuf_q      <= '0;
            iLine_q     <= '0;
            tLine_q     <= '0;
            lineIdx_q   <= '0;
            lineValid_q <= 1'b0;
            frameDone_q <= 1'b0;
        end else begin
            if (accept) begin
                iBuf_q[col_q * PIXEL_SIZE +: PIXEL_SIZE] <= I_pix_i;
                tBuf_q[col_q * TPIX_W +: TPIX_W]         <= T_pix_i;
            end
            if (lineLoad) begin
                iLine_q   <= iLineNext;
                tLine_q   <= tLineNext;
                lineIdx_q <= line_q;
            end
            lineValid_q <= lineLoad;
            frameDone_q <= (state_q == DONE);
        end
    end

    assign I_in_line_o  = iLine_q;
    assign T_in_line_o  = tLine_q;
    assign line_idx_o   = lineIdx_q;
    assign line_valid_o = lineValid_q;
    assign frame_done_o = frameDone_q;

endmodule

// File: tb/tb_line_streamer.sv
// ----------------------------------------------------------------------------
// tb_line_streamer
// Directed scoreboard bench for line_streamer with LINE_SIZE=4,
// NUM_OF_LINES=2, one template. The stimulus pushes hand-computed expected
// lines into a queue. A monitor pops and compares them whenever line_valid
// is seen, and it also tracks acc_clear / frame_done pulses.
// ----------------------------------------------------------------------------
module tb_line_streamer;

    localparam int PS = 8;
    localparam int LS = 4;
    localparam int NT = 1;
    localparam int NL = 2;

    typedef struct {
        logic [0:0]  idx;
        logic [31:0] iLine;
        logic [31:0] tLine;
        int          expCyc;
    } lineExp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        pix_valid;
    logic        pix_ready;
    logic [7:0]  I_pix;
    logic [7:0]  T_pix;
    logic [31:0] I_in_line;
    logic [31:0] T_in_line;
    logic        line_valid;
    logic [0:0]  line_idx;
    logic        acc_clear;
    logic        frame_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int lastAcceptCyc = 0;
    int lastLvCyc = -10;
    int accCount = 0;
    int fdCount = 0;
    int lineCount = 0;
    int accBase, fdBase, lineBase;
    lineExp_t expQ[$];
    lineExp_t popped;

    line_streamer #(
        .PIXEL_SIZE   (PS),
        .LINE_SIZE    (LS),
        .NUM_TEMPLATES(NT),
        .NUM_OF_LINES (NL)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .start_i     (start),
        .pix_valid_i (pix_valid),
        .pix_ready_o (pix_ready),
        .I_pix_i     (I_pix),
        .T_pix_i     (T_pix),
        .I_in_line_o (I_in_line),
        .T_in_line_o (T_in_line),
        .line_valid_o(line_valid),
        .line_idx_o  (line_idx),
        .acc_clear_o (acc_clear),
        .frame_done_o(frame_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Presents one pixel after 'gap' idle cycles and holds it until accepted.
    task automatic applyStimulus(input logic [7:0] iv, input logic [7:0] tv, input int gap);
        int waited;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        pix_valid = 1'b1;
        I_pix     = iv;
        T_pix     = tv;
        waited    = 0;
        while (!pix_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!pix_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout actual=0 expected=1 (pixel %0d)", iv);
        end
        lastAcceptCyc = cyc;
        @(posedge clk);
        #1 pix_valid = 1'b0;
    endtask

    task automatic pushLine(input logic [0:0] idx, input logic [31:0] iL, input logic [31:0] tL);
        lineExp_t e;
        e.idx    = idx;
        e.iLine  = iL;
        e.tLine  = tL;
        e.expCyc = lastAcceptCyc + 1;
        expQ.push_back(e);
    endtask

    task automatic startFrame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic snapCounts();
        accBase  = accCount;
        fdBase   = fdCount;
        lineBase = lineCount;
    endtask

    task automatic checkFrameEnd(input string tag);
        checkOutput({tag, "_acc_clear_count"}, 64'(accCount - accBase), 64'd1);
        checkOutput({tag, "_frame_done_count"}, 64'(fdCount - fdBase), 64'd1);
        checkOutput({tag, "_line_count"}, 64'(lineCount - lineBase), 64'd2);
        checkOutput({tag, "_queue_empty"}, 64'(expQ.size()), 64'd0);
        checkOutput({tag, "_pix_ready_idle"}, 64'(pix_ready), 64'd0);
    endtask

    // Monitor: consumes the scoreboard on every line strobe and watches the
    // control pulses.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("strobe_exclusive",
                        64'((line_valid && acc_clear) || (line_valid && frame_done) ||
                            (acc_clear && frame_done)), 64'd0);
            if (acc_clear) accCount++;
            if (line_valid) begin
                lineCount++;
                lastLvCyc = cyc;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_line_valid", 64'd1, 64'd0);
                end else begin
                    popped = expQ.pop_front();
                    checkOutput("line_idx", 64'(line_idx), 64'(popped.idx));
                    checkOutput("I_in_line", 64'(I_in_line), 64'(popped.iLine));
                    checkOutput("T_in_line", 64'(T_in_line), 64'(popped.tLine));
                    checkOutput("line_latency", 64'(cyc), 64'(popped.expCyc));
                end
            end
            if (frame_done) begin
                fdCount++;
                checkOutput("frame_done_timing", 64'(cyc), 64'(lastLvCyc + 1));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        pix_valid = 1'b0;
        I_pix     = '0;
        T_pix     = '0;
        waitCycles(3);
        checkOutput("rst_pix_ready", 64'(pix_ready), 64'd0);
        checkOutput("rst_line_valid", 64'(line_valid), 64'd0);
        checkOutput("rst_acc_clear", 64'(acc_clear), 64'd0);
        checkOutput("rst_frame_done", 64'(frame_done), 64'd0);
        checkOutput("rst_I_in_line", 64'(I_in_line), 64'd0);
        checkOutput("rst_T_in_line", 64'(T_in_line), 64'd0);
        checkOutput("rst_line_idx", 64'(line_idx), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        waitCycles(2);

        $display("[TB] frame A: continuous line, gapped line, stray start pulses");
        snapCounts();
        startFrame();
        applyStimulus(8'd1, 8'd10, 0);
        applyStimulus(8'd2, 8'd20, 0);
        applyStimulus(8'd3, 8'd30, 0);
        applyStimulus(8'd4, 8'd40, 0);
        pushLine(1'b0, 32'h04030201, 32'h281E140A);
        applyStimulus(8'd5, 8'd50, 0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        applyStimulus(8'd6, 8'd60, 2);
        applyStimulus(8'd7, 8'd70, 0);
        applyStimulus(8'd8, 8'd80, 1);
        pushLine(1'b1, 32'h08070605, 32'h50463C32);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitCycles(5);
        checkFrameEnd("frameA");

        $display("[TB] frame B: T=10*I, pixel offered before ready");
        snapCounts();
        @(negedge clk);
        pix_valid = 1'b1;
        I_pix     = 8'd9;
        T_pix     = 8'd90;
        waitCycles(3);
        startFrame();
        applyStimulus(8'd9, 8'd90, 0);
        applyStimulus(8'd10, 8'd100, 0);
        applyStimulus(8'd11, 8'd110, 0);
        applyStimulus(8'd12, 8'd120, 0);
        pushLine(1'b0, 32'h0C0B0A09, 32'h786E645A);
        applyStimulus(8'd13, 8'd130, 0);
        applyStimulus(8'd14, 8'd140, 0);
        applyStimulus(8'd15, 8'd150, 0);
        applyStimulus(8'd16, 8'd160, 0);
        pushLine(1'b1, 32'h100F0E0D, 32'hA0968C82);
        waitCycles(5);
        checkFrameEnd("frameB");
        checkOutput("hold_I_in_line", 64'(I_in_line), 64'h100F0E0D);
        checkOutput("hold_T_in_line", 64'(T_in_line), 64'hA0968C82);
        checkOutput("hold_line_idx", 64'(line_idx), 64'd1);

        $display("[TB] reset in the middle of a line");
        fdBase = fdCount;
        startFrame();
        applyStimulus(8'hAA, 8'hBB, 0);
        applyStimulus(8'hCC, 8'hDD, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        waitCycles(1);
        checkOutput("mid_rst_pix_ready", 64'(pix_ready), 64'd0);
        checkOutput("mid_rst_I_in_line", 64'(I_in_line), 64'd0);
        checkOutput("mid_rst_T_in_line", 64'(T_in_line), 64'd0);
        checkOutput("mid_rst_line_idx", 64'(line_idx), 64'd0);
        checkOutput("mid_rst_line_valid", 64'(line_valid), 64'd0);
        waitCycles(3);
        checkOutput("mid_rst_no_frame_done", 64'(fdCount - fdBase), 64'd0);
        checkOutput("mid_rst_still_idle", 64'(pix_ready), 64'd0);

        $display("[TB] frame C: fresh frame after reset");
        snapCounts();
        startFrame();
        applyStimulus(8'd21, 8'd121, 0);
        applyStimulus(8'd22, 8'd122, 1);
        applyStimulus(8'd23, 8'd123, 0);
        applyStimulus(8'd24, 8'd124, 0);
        pushLine(1'b0, 32'h18171615, 32'h7C7B7A79);
        applyStimulus(8'd25, 8'd125, 0);
        applyStimulus(8'd26, 8'd126, 0);
        applyStimulus(8'd27, 8'd127, 3);
        applyStimulus(8'd28, 8'd128, 0);
        pushLine(1'b1, 32'h1C1B1A19, 32'h807F7E7D);
        waitCycles(5);
        checkFrameEnd("frameC");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
